addition_multiply: RTL and testbench
====================================

ADDITION_MULTIPLY -- requirements
Module: addition_multiply

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (two's complement signed); all values below assume WIDTH=16.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-high.
REQ-004 add_in1  input  WIDTH  adder operand A (signed).
REQ-005 add_in2  input  WIDTH  adder operand B (signed).
REQ-006 sub  input  1  0 = A+B, 1 = A-B; sampled with add_start.
REQ-007 add_start  input  1  single-cycle request to start add/sub.
REQ-008 add_out  output  WIDTH  add/sub result, low WIDTH bits.
REQ-009 add_finish  output  1  one-cycle pulse, add_out valid.
REQ-010 add_ovf  output  1  signed overflow of last add/sub.
REQ-011 mul_in1  input  WIDTH  multiplicand (signed).
REQ-012 mul_in2  input  WIDTH  multiplier (signed).
REQ-013 mul_start  input  1  single-cycle request to start multiply.
REQ-014 mul_out  output  WIDTH  product, low WIDTH bits.
REQ-015 mul_finish  output  1  one-cycle pulse, mul_out valid.
REQ-016 mul_ovf  output  1  full signed product not representable in WIDTH bits.

Function
REQ-017 Adder and multiplier SHALL be independent units; both may run concurrently.
REQ-018 Adder: operands and sub captured on the edge where add_start=1; add_out, add_ovf updated and add_finish=1 on the next edge (latency 1 cycle); add_finish low the following cycle.
REQ-019 Subtraction SHALL be A + ~B + 1; result wraps modulo 2^WIDTH.
REQ-020 add_ovf=1 when operands (B inverted for sub) share sign and result sign differs; else 0.
REQ-021 Adder SHALL accept add_start every cycle (back-to-back ops, one finish per start).
REQ-022 Multiplier FSM states: IDLE, BUSY, DONE.
REQ-023 IDLE: on mul_start=1 capture operands, clear 2*WIDTH accumulator, counter=0, go BUSY.
REQ-024 BUSY: one shift-add (signed, Booth radix-2 or sign-corrected shift-add) iteration per cycle; after WIDTH iterations go DONE.
REQ-025 DONE: mul_out = product[WIDTH-1:0], mul_ovf set, mul_finish=1 for exactly this cycle; return to IDLE next edge.
REQ-026 mul_finish SHALL assert on the (WIDTH+1)th rising edge after the edge sampling mul_start (17 for WIDTH=16).
REQ-027 mul_ovf=1 iff product[2*WIDTH-1:WIDTH-1] not all equal.
REQ-028 mul_start while BUSY or DONE SHALL be ignored; operands in flight unaffected.
REQ-029 add_out/add_ovf and mul_out/mul_ovf SHALL hold their values until the next completion of the same unit.
REQ-030 Inputs need not be held stable after the start cycle.

Reset
REQ-031 nRST=1 SHALL immediately force: add_out=0, add_finish=0, add_ovf=0, mul_out=0, mul_finish=0, mul_ovf=0, multiplier FSM=IDLE, counter and accumulator=0.
REQ-032 Reset during BUSY SHALL abort the multiply with no mul_finish pulse; a start on the first edge after release SHALL be accepted.
REQ-033 Start inputs asserted while nRST=1 SHALL be ignored.

Verification
REQ-034 add_in1=12, add_in2=5, sub=1, add_start 1 cycle -> next edge add_out=7, add_finish=1, add_ovf=0; add_finish=0 one cycle later.
REQ-035 add_in1=0x7FFF, add_in2=0x0001, sub=0 -> add_out=0x8000, add_ovf=1; then 0x8000-0x0001 -> 0x7FFF, add_ovf=1.
REQ-036 mul_in1=7, mul_in2=0xFFFD (-3), mul_start 1 cycle -> mul_finish=1 exactly 17 edges later, mul_out=0xFFEB (-21), mul_ovf=0; mul_out held afterward.
REQ-037 mul_in1=300, mul_in2=300 -> mul_out=0x5F90, mul_ovf=1; 0x8000 x 0xFFFF -> mul_out=0x8000, mul_ovf=1.
REQ-038 Start multiply 5x5, pulse mul_start with 9x9 at cycle 5 -> only one finish, mul_out=25; assert nRST at cycle 8 of a new multiply -> no finish, all outputs 0, new 2x3 after release yields 6 at 17 edges.

Source files
------------

// File: rtl/addition_multiply.sv
// Independent signed add/sub unit (1-cycle latency) and iterative
// shift-add signed multiplier (WIDTH+1 cycle latency), sharing clk/nRST.
//
// Ports:
//   clk, nRST (async, active-high)
//   add_in1, add_in2, sub, add_start -> add_out, add_finish, add_ovf
//   mul_in1, mul_in2, mul_start      -> mul_out, mul_finish, mul_ovf
module addition_multiply #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH-1:0] add_in2,
    input  logic             sub,
    input  logic             add_start,
    output logic [WIDTH-1:0] add_out,
    output logic             add_finish,
    output logic             add_ovf,
    input  logic [WIDTH-1:0] mul_in1,
    input  logic [WIDTH-1:0] mul_in2,
    input  logic             mul_start,
    output logic [WIDTH-1:0] mul_out,
    output logic             mul_finish,
    output logic             mul_ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // ---------------- adder ----------------
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             add_pend;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // Subtraction is A + ~B + 1; the +1 rides in as the carry-in.
    always_comb begin
        b_eff   = sub_q ? ~b_q : b_q;
        sum     = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
        sum_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            add_pend   <= 1'b0;
            add_out    <= '0;
            add_ovf    <= 1'b0;
            add_finish <= 1'b0;
        end else begin
            add_pend   <= add_start;
            add_finish <= add_pend;
            if (add_start) begin
                a_q   <= add_in1;
                b_q   <= add_in2;
                sub_q <= sub;
            end
            if (add_pend) begin
                add_out <= sum;
                add_ovf <= sum_ovf;
            end
        end
    end

    // ---------------- multiplier ----------------
    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               last;
    logic [WIDTH:0]     hi;
    logic               prod_ovf;

    // The multiplier's MSB carries weight -2^(WIDTH-1), so the final
    // partial product is subtracted instead of added.
    always_comb begin
        last     = (cnt == CW'(WIDTH - 1));
        hi       = acc[2*WIDTH-1:WIDTH-1];
        prod_ovf = !((&hi) || !(|hi));
    end

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            mul_out    <= '0;
            mul_ovf    <= 1'b0;
            mul_finish <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mul_finish <= 1'b0;
                    if (mul_start) begin
                        mcand  <= {{WIDTH{mul_in1[WIDTH-1]}}, mul_in1};
                        mplier <= mul_in2;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(WIDTH)) begin
                        // Extra cycle: publish the finished product.
                        mul_out    <= acc[WIDTH-1:0];
                        mul_ovf    <= prod_ovf;
                        mul_finish <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= last ? acc - mcand : acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    mul_finish <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mul_finish <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addition_multiply.sv
// Directed self-checking bench for addition_multiply (WIDTH=16).
// Adder and multiplier vectors are table driven; corner cases are scripted.
module tb_addition_multiply;

    localparam int W = 16;

    logic         clk;
    logic         nRST;
    logic [W-1:0] add_in1;
    logic [W-1:0] add_in2;
    logic         sub;
    logic         add_start;
    logic [W-1:0] add_out;
    logic         add_finish;
    logic         add_ovf;
    logic [W-1:0] mul_in1;
    logic [W-1:0] mul_in2;
    logic         mul_start;
    logic [W-1:0] mul_out;
    logic         mul_finish;
    logic         mul_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    addition_multiply #(.WIDTH(W)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .sub        (sub),
        .add_start  (add_start),
        .add_out    (add_out),
        .add_finish (add_finish),
        .add_ovf    (add_ovf),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_start  (mul_start),
        .mul_out    (mul_out),
        .mul_finish (mul_finish),
        .mul_ovf    (mul_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] out;
        logic         ovf;
    } add_vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         ovf;
    } mul_vec_t;

    add_vec_t av[8];
    mul_vec_t mv[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " add_out"}, 32'(add_out), 32'd0);
        check({name, " add_finish"}, 32'(add_finish), 32'd0);
        check({name, " add_ovf"}, 32'(add_ovf), 32'd0);
        check({name, " mul_out"}, 32'(mul_out), 32'd0);
        check({name, " mul_finish"}, 32'(mul_finish), 32'd0);
        check({name, " mul_ovf"}, 32'(mul_ovf), 32'd0);
    endtask

    // Start a multiply, scramble inputs after the start cycle, and
    // count edges until mul_finish (bounded).
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_out, input logic exp_ovf,
                           input string name);
        int n;
        mul_in1   = a;
        mul_in2   = b;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        mul_in1   = W'($urandom);
        mul_in2   = W'($urandom);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (mul_finish) break;
        end
        check({name, " latency"}, 32'(n), 32'd17);
        check({name, " mul_out"}, 32'(mul_out), 32'(exp_out));
        check({name, " mul_ovf"}, 32'(mul_ovf), 32'(exp_ovf));
        tick();
        check({name, " finish drop"}, 32'(mul_finish), 32'd0);
        check({name, " hold"}, 32'(mul_out), 32'(exp_out));
        tick();
    endtask

    initial begin
        int nfin;
        int fin_edge;

        av[0] = '{16'd12,   16'd5,    1'b1, 16'd7,    1'b0};
        av[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
        av[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
        av[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
        av[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        av[5] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1};
        av[6] = '{16'd100,  16'd200,  1'b1, 16'hFF9C, 1'b0};
        av[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};

        mv[0] = '{16'd7,    16'hFFFD, 16'hFFEB, 1'b0};
        mv[1] = '{16'd300,  16'd300,  16'h5F90, 1'b1};
        mv[2] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b1};
        mv[3] = '{16'h0000, 16'h1234, 16'h0000, 1'b0};
        mv[4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b0};
        mv[5] = '{16'h8000, 16'h0001, 16'h8000, 1'b0};
        mv[6] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        mv[7] = '{16'd181,  16'd181,  16'h7FF9, 1'b0};
        mv[8] = '{16'd256,  16'd128,  16'h8000, 1'b1};

        nRST      = 1'b1;
        add_in1   = '0;
        add_in2   = '0;
        sub       = 1'b0;
        add_start = 1'b0;
        mul_in1   = '0;
        mul_in2   = '0;
        mul_start = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        nRST = 1'b0;
        tick();

        // Single add/sub: 1-cycle latency, one-cycle finish pulse.
        for (int i = 0; i < 8; i++) begin
            add_in1   = av[i].a;
            add_in2   = av[i].b;
            sub       = av[i].s;
            add_start = 1'b1;
            tick();
            add_start = 1'b0;
            add_in1   = W'($urandom);
            add_in2   = W'($urandom);
            sub       = 1'($urandom);
            tick();
            check($sformatf("add%0d finish", i), 32'(add_finish), 32'd1);
            check($sformatf("add%0d out", i), 32'(add_out), 32'(av[i].out));
            check($sformatf("add%0d ovf", i), 32'(add_ovf), 32'(av[i].ovf));
            tick();
            check($sformatf("add%0d drop", i), 32'(add_finish), 32'd0);
            check($sformatf("add%0d hold", i), 32'(add_out), 32'(av[i].out));
        end

        // Back-to-back adds: one result per cycle.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                add_in1   = av[i].a;
                add_in2   = av[i].b;
                sub       = av[i].s;
                add_start = 1'b1;
            end else begin
                add_start = 1'b0;
            end
            tick();
            if (i > 0) begin
                check($sformatf("b2b%0d finish", i - 1), 32'(add_finish), 32'd1);
                check($sformatf("b2b%0d out", i - 1), 32'(add_out),
                      32'(av[i-1].out));
                check($sformatf("b2b%0d ovf", i - 1), 32'(add_ovf),
                      32'(av[i-1].ovf));
            end
        end
        tick();
        check("b2b tail drop", 32'(add_finish), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_mul(mv[i].a, mv[i].b, mv[i].out, mv[i].ovf,
                    $sformatf("mul%0d", i));
        end

        // Starts during BUSY (edge 5) and DONE (edge 18) are ignored;
        // an add runs concurrently.
        mul_in1   = 16'd5;
        mul_in2   = 16'd5;
        mul_start = 1'b1;
        tick();
        nfin     = 0;
        fin_edge = 0;
        for (int k = 1; k <= 30; k++) begin
            mul_start = (k == 5) || (k == 18);
            mul_in1   = (k == 5) ? 16'd9 : 16'd11;
            mul_in2   = (k == 5) ? 16'd9 : 16'd11;
            add_start = (k == 10);
            add_in1   = 16'd3;
            add_in2   = 16'd4;
            sub       = 1'b0;
            tick();
            if (k == 11) begin
                check("concurrent add finish", 32'(add_finish), 32'd1);
                check("concurrent add out", 32'(add_out), 32'd7);
            end
            if (mul_finish) begin
                nfin++;
                fin_edge = k;
            end
        end
        mul_start = 1'b0;
        add_start = 1'b0;
        check("ignore finishes", 32'(nfin), 32'd1);
        check("ignore finish edge", 32'(fin_edge), 32'd17);
        check("ignore mul_out", 32'(mul_out), 32'd25);

        // Reset at cycle 8 of a multiply aborts it and clears outputs.
        add_in1   = 16'h7FFF;
        add_in2   = 16'd1;
        add_start = 1'b1;
        tick();
        add_start = 1'b0;
        mul_in1   = 16'd100;
        mul_in2   = 16'd100;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        nfin = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mul_finish) nfin++;
        end
        nRST = 1'b1;
        #1;
        check_all_zero("async reset");
        mul_in1   = 16'd9;
        mul_in2   = 16'd9;
        mul_start = 1'b1;
        add_start = 1'b1;
        tick();
        tick();
        check_all_zero("start in reset");
        mul_start = 1'b0;
        add_start = 1'b0;
        nRST      = 1'b0;
        tick();
        tick();
        check("start in reset add", 32'(add_finish), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mul_finish) nfin++;
        end
        check("aborted no finish", 32'(nfin), 32'd0);
        check("aborted mul_out", 32'(mul_out), 32'd0);

        // Start on the first edge after release is accepted.
        nRST = 1'b1;
        tick();
        nRST      = 1'b0;
        mul_in1   = 16'd2;
        mul_in2   = 16'd3;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        nfin     = 0;
        fin_edge = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (mul_finish) begin
                nfin++;
                fin_edge = k;
            end
        end
        check("post-reset finishes", 32'(nfin), 32'd1);
        check("post-reset edge", 32'(fin_edge), 32'd17);
        check("post-reset mul_out", 32'(mul_out), 32'd6);
        check("post-reset mul_ovf", 32'(mul_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
